// File: rtl/ddr_burst_tester.sv
// ddr_burst_tester: AXI4 master that writes pattern bursts to DDR, reads them back and counts mismatches
module ddr_burst_tester #(
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_BURST_LEN = 16,
  parameter int C_NUM_BURSTS = 4,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = 'h4000_0000,
  parameter int C_PATTERN_MODE = 0
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic M00_AXI_INIT_AXI_TXN,
  output logic M00_AXI_TXN_DONE,
  output logic M00_AXI_ERROR,
  output logic [15:0] M00_AXI_ERR_COUNT,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] M00_AXI_AWADDR,
  output logic [7:0] M00_AXI_AWLEN,
  output logic [2:0] M00_AXI_AWSIZE,
  output logic [1:0] M00_AXI_AWBURST,
  output logic M00_AXI_AWVALID,
  input  logic M00_AXI_AWREADY,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] M00_AXI_WDATA,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] M00_AXI_WSTRB,
  output logic M00_AXI_WLAST,
  output logic M00_AXI_WVALID,
  input  logic M00_AXI_WREADY,
  input  logic [1:0] M00_AXI_BRESP,
  input  logic M00_AXI_BVALID,
  output logic M00_AXI_BREADY,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] M00_AXI_ARADDR,
  output logic [7:0] M00_AXI_ARLEN,
  output logic [2:0] M00_AXI_ARSIZE,
  output logic [1:0] M00_AXI_ARBURST,
  output logic M00_AXI_ARVALID,
  input  logic M00_AXI_ARREADY,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] M00_AXI_RDATA,
  input  logic [1:0] M00_AXI_RRESP,
  input  logic M00_AXI_RLAST,
  input  logic M00_AXI_RVALID,
  output logic M00_AXI_RREADY
);
  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int NBW = $clog2(C_NUM_BURSTS + 1);
  localparam logic [AW-1:0] STRIDE = AW'(C_M00_AXI_BURST_LEN * (DW / 8));
  localparam logic [7:0] LAST_BEAT = 8'(C_M00_AXI_BURST_LEN - 1);
  localparam logic [NBW-1:0] LAST_BURST = NBW'(C_NUM_BURSTS - 1);
  localparam logic [31:0] SEED = 32'hACE1_ACE1;
  localparam logic [2:0] S_IDLE = 3'd0, S_AW = 3'd1, S_W = 3'd2, S_B = 3'd3, S_AR = 3'd4, S_R = 3'd5, S_DONE = 3'd6;
  logic [2:0] state;
  logic init_q;
  logic [NBW-1:0] burst;
  logic [7:0] beat;
  logic [DW-1:0] pidx;
  logic [31:0] lfsr;
  logic [15:0] err_count;
  logic start, last_beat, last_burst, r_hs, b_hs;
  logic [DW-1:0] expected;
  logic [31:0] lfsr_next;
  logic [1:0] inc;
  logic [16:0] sum;
  assign start = M00_AXI_INIT_AXI_TXN & ~init_q & (state == S_IDLE | state == S_DONE);
  assign last_beat = beat == LAST_BEAT;
  assign last_burst = burst == LAST_BURST;
  assign r_hs = state == S_R && M00_AXI_RVALID;
  assign b_hs = state == S_B && M00_AXI_BVALID;
  assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign sum = {1'b0, err_count} + 17'(inc);
  assign M00_AXI_AWADDR = C_TARGET_BASE_ADDR + AW'(burst) * STRIDE;
  assign M00_AXI_ARADDR = M00_AXI_AWADDR;
  assign M00_AXI_AWLEN = LAST_BEAT;
  assign M00_AXI_ARLEN = LAST_BEAT;
  assign M00_AXI_AWSIZE = 3'($clog2(DW / 8));
  assign M00_AXI_ARSIZE = 3'($clog2(DW / 8));
  assign M00_AXI_AWBURST = 2'b01;
  assign M00_AXI_ARBURST = 2'b01;
  assign M00_AXI_AWVALID = state == S_AW;
  assign M00_AXI_WVALID = state == S_W;
  assign M00_AXI_WLAST = state == S_W && last_beat;
  assign M00_AXI_WDATA = expected;
  assign M00_AXI_WSTRB = '1;
  assign M00_AXI_BREADY = state == S_B;
  assign M00_AXI_ARVALID = state == S_AR;
  assign M00_AXI_RREADY = state == S_R;
  assign M00_AXI_TXN_DONE = state == S_DONE;
  assign M00_AXI_ERROR = err_count != 16'd0;
  assign M00_AXI_ERR_COUNT = err_count;
  // pattern for the current beat and number of error events seen this cycle
  always_comb begin
    expected = C_PATTERN_MODE != 0 ? {(DW / 32){lfsr}} : pidx + DW'(1);
    inc = r_hs ? 2'(M00_AXI_RDATA != expected || M00_AXI_RRESP != 2'b00) + 2'(M00_AXI_RLAST != last_beat)
               : 2'(b_hs && M00_AXI_BRESP != 2'b00);
  end
  // run sequencer: one write burst then its response at a time, then one read burst at a time
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= S_IDLE;
      init_q <= 1'b0;
      burst <= '0;
      beat <= '0;
      pidx <= '0;
      lfsr <= SEED;
      err_count <= '0;
    end else begin
      init_q <= M00_AXI_INIT_AXI_TXN;
      err_count <= sum[16] ? 16'hFFFF : sum[15:0];
      if (start) begin
        state <= S_AW;
        burst <= '0;
        beat <= '0;
        pidx <= '0;
        lfsr <= SEED;
        err_count <= '0;
      end else begin
        case (state)
          S_AW: if (M00_AXI_AWREADY) state <= S_W;
          S_W: if (M00_AXI_WREADY) begin
            beat <= last_beat ? 8'd0 : beat + 8'd1;
            pidx <= pidx + DW'(1);
            lfsr <= lfsr_next;
            if (last_beat) state <= S_B;
          end
          S_B: if (M00_AXI_BVALID) begin
            burst <= last_burst ? '0 : burst + NBW'(1);
            state <= last_burst ? S_AR : S_AW;
            if (last_burst) begin
              pidx <= '0;
              lfsr <= SEED;
            end
          end
          S_AR: if (M00_AXI_ARREADY) state <= S_R;
          S_R: if (M00_AXI_RVALID) begin
            beat <= last_beat ? 8'd0 : beat + 8'd1;
            pidx <= pidx + DW'(1);
            lfsr <= lfsr_next;
            if (last_beat) begin
              burst <= burst + NBW'(1);
              state <= last_burst ? S_DONE : S_AR;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/ddr_burst_tester.md
Name:
ddr_burst_tester

Overview:
Parametrised AXI4 full-master traffic generator/checker for the DDR path: on an init pulse it writes NUM_BURSTS INCR bursts of a selectable data pattern, reads them back, compares each beat, and reports done, a sticky error and a mismatch count. It replaces the single-pattern M00_AXI test master behind the same BD wrapper.

Parameters:
C_M00_AXI_ADDR_WIDTH, 32, address width
C_M00_AXI_DATA_WIDTH, 32, data width; legal values 32/64/128
C_M00_AXI_BURST_LEN, 16, beats per burst (1..256); BURST_LEN*DATA_WIDTH/8 <= 4096
C_NUM_BURSTS, 4, bursts per run (>=1)
C_TARGET_BASE_ADDR, 32'h4000_0000, first burst address, aligned to BURST_LEN*DATA_WIDTH/8
C_PATTERN_MODE, 0, 0 = incrementing, 1 = LFSR

Ports:
ACLK  in  1  single clock, all logic on rising edge
ARESETN  in  1  synchronous active-low reset
M00_AXI_INIT_AXI_TXN  in  1  start; rising edge starts a run
M00_AXI_TXN_DONE  out  1  run complete (level)
M00_AXI_ERROR  out  1  sticky: ERR_COUNT != 0
M00_AXI_ERR_COUNT  out  16  mismatch/response-error count, saturating
M00_AXI_AWADDR  out  ADDR_WIDTH  write burst address
M00_AXI_AWLEN  out  8  BURST_LEN-1
M00_AXI_AWSIZE / M00_AXI_ARSIZE  out  3 each  clog2(DATA_WIDTH/8)
M00_AXI_AWBURST / M00_AXI_ARBURST  out  2 each  2'b01 (INCR)
M00_AXI_AWVALID  out  1  / M00_AXI_AWREADY  in  1  AW handshake
M00_AXI_WDATA  out  DATA_WIDTH  write pattern beat
M00_AXI_WSTRB  out  DATA_WIDTH/8  all ones
M00_AXI_WLAST  out  1  last beat of burst
M00_AXI_WVALID  out  1  / M00_AXI_WREADY  in  1  W handshake
M00_AXI_BRESP  in  2  write response
M00_AXI_BVALID  in  1  / M00_AXI_BREADY  out  1  B handshake
M00_AXI_ARADDR  out  ADDR_WIDTH  read burst address
M00_AXI_ARLEN  out  8  BURST_LEN-1
M00_AXI_ARVALID  out  1  / M00_AXI_ARREADY  in  1  AR handshake
M00_AXI_RDATA  in  DATA_WIDTH  read data
M00_AXI_RRESP  in  2  read response
M00_AXI_RLAST  in  1  last read beat
M00_AXI_RVALID  in  1  / M00_AXI_RREADY  out  1  R handshake

Behaviour:
- Reset (ARESETN=0 at ACLK edge): state IDLE; all VALID/READY outputs 0, TXN_DONE 0, ERROR 0, ERR_COUNT 0, counters 0, LFSR = seed. Reset mid-run abandons outstanding transactions; outputs drop on that edge.
- Start: INIT registered; start = INIT & ~INIT_q; honoured only in IDLE or DONE, ignored otherwise. Start clears TXN_DONE, ERR_COUNT, counters, reseeds pattern; next state WRITE.
- FSM: IDLE -> WRITE -> READ -> DONE; DONE -> WRITE on start. One burst outstanding at a time on each phase.
- Burst b address = BASE + b*BURST_LEN*(DATA_WIDTH/8), same for AW and AR. AWVALID/ARVALID held, address stable until READY. WVALID asserts cycle after AW handshake; each beat held stable until WREADY; WLAST on beat BURST_LEN-1. BREADY=1 from WLAST handshake until BVALID; next AW follows B handshake. After last B, pattern reseeds, state READ.
- Pattern, global beat index i = 0..NUM_BURSTS*BURST_LEN-1: mode 0 data = (i+1) mod 2^DATA_WIDTH; mode 1 data = 32-bit Fibonacci LFSR (taps 32,22,2,1, seed 32'hACE1_ACE1, beat 0 = seed, advance per beat) replicated DATA_WIDTH/32 times.
- READ: RREADY=1 from AR handshake through RLAST beat. Per R handshake: RDATA != expected or RRESP != 0 -> one error. RLAST on wrong beat or missing on beat BURST_LEN-1 -> one additional error; burst still ends at beat count. BRESP != 0 -> one error.
- Errors: ERR_COUNT += 1 per event, saturates at 16'hFFFF; ERROR = ERR_COUNT != 0, combinational from register. Simultaneous data and RLAST errors on one beat count 2.
- DONE: TXN_DONE=1, held until next start or reset; all VALID/READY 0.

Test Plan:
1. Defaults, VIP memory slave always ready, INIT pulse -> AWADDR 0x4000_0000/0x40/0x80/0xC0, AWLEN 15, WDATA 1..64, reads match, TXN_DONE=1, ERROR=0, ERR_COUNT=0.
2. Random AWREADY/WREADY/ARREADY/RVALID backpressure -> same result; no VALID drop or payload change before handshake (assertions).
3. Overwrite memory word 0x4000_0044 with 0xDEADBEEF after write phase -> ERR_COUNT=1, ERROR=1, TXN_DONE=1.
4. SLVERR on 2nd BRESP -> read phase still runs, ERR_COUNT=1, ERROR=1; 2nd INIT from DONE -> ERR_COUNT cleared, clean rerun ERR_COUNT=0.
5. PATTERN_MODE=1, DATA_WIDTH=64, BURST_LEN=1, NUM_BURSTS=8 -> first WDATA 64'hACE1ACE1_ACE1ACE1, addresses step 8, AWLEN 0, WLAST every beat, ERR_COUNT=0.
6. ARESETN low 2 cycles during burst 2 write -> all VALIDs 0, TXN_DONE 0; INIT pulse while busy ignored; post-reset INIT gives clean pass.
